// File: rtl/truth_table_eval.sv
// truth_table_eval: programmable N_IN-input boolean function.
// The active table TT is evaluated one vector per cycle. It can be replaced
// by a serial LSB-first load through a shadow table, and it can be swept
// exhaustively into sweep_sig for readback.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | accepts evaluations; cfg_load > sweep_start > in_valid
// LOAD  | shifting cfg_bit into the shadow table, one bit per cfg_bit_valid
// SWEEP | writing sweep_sig[v] <= TT[v] for v = 0 .. 2**N_IN-1
module truth_table_eval #(
  parameter int                   N_IN       = 4,
  parameter logic [2**N_IN-1:0]   DEFAULT_TT = 16'h1FDE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [N_IN-1:0]      in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic                 out,
  input  logic                 cfg_load,
  input  logic                 cfg_bit_valid,
  input  logic                 cfg_bit,
  output logic                 cfg_done,
  input  logic                 sweep_start,
  output logic                 sweep_busy,
  output logic                 sweep_done,
  output logic [2**N_IN-1:0]   sweep_sig
);

  localparam int TT_W = 2**N_IN;
  // The counter is one bit wider than an address so it never wraps; both
  // LOAD and SWEEP terminate by comparing against the last address.
  localparam logic [N_IN:0] LAST_IDX = (N_IN+1)'(TT_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SWEEP = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [TT_W-1:0]   tt;
  logic [TT_W-1:0]   shadow;
  logic [TT_W-1:0]   shadow_nxt;
  logic [N_IN:0]     cnt;
  logic [N_IN-1:0]   idx;
  logic              cnt_last;
  logic              load_enter;
  logic              sweep_enter;
  logic              eval_acc;
  logic              bit_acc;
  logic              load_commit;
  logic              sweep_last;

  assign idx      = cnt[N_IN-1:0];
  assign cnt_last = (cnt == LAST_IDX);

  // Request decode: IDLE priority is cfg_load, then sweep_start, then in_valid.
  always_comb begin
    in_ready    = 1'b0;
    load_enter  = 1'b0;
    sweep_enter = 1'b0;
    eval_acc    = 1'b0;
    bit_acc     = 1'b0;
    load_commit = 1'b0;
    sweep_last  = 1'b0;
    if (state == IDLE) begin
      in_ready    = ~cfg_load & ~sweep_start;
      load_enter  = cfg_load;
      sweep_enter = ~cfg_load & sweep_start;
      eval_acc    = in_valid & ~cfg_load & ~sweep_start;
    end
    if (state == LOAD) begin
      bit_acc     = cfg_bit_valid;
      load_commit = cfg_bit_valid & cnt_last;
    end
    if (state == SWEEP) begin
      sweep_last  = cnt_last;
    end
  end

  // Shadow table with the incoming bit merged in, so the final bit is part of
  // the table committed on the same edge.
  always_comb begin
    shadow_nxt = shadow;
    if (bit_acc) begin
      shadow_nxt[idx] = cfg_bit;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (load_enter) begin
          state_nxt = LOAD;
        end else if (sweep_enter) begin
          state_nxt = SWEEP;
        end
      end
      LOAD: begin
        if (load_commit) begin
          state_nxt = IDLE;
        end
      end
      SWEEP: begin
        if (sweep_last) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Evaluation path: one-cycle latency, out holds between results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= eval_acc;
      if (eval_acc) begin
        out <= tt[in_data];
      end
    end
  end

  // Table load, sweep capture and the shared bit/vector counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tt         <= DEFAULT_TT;
      shadow     <= '0;
      cnt        <= '0;
      cfg_done   <= 1'b0;
      sweep_busy <= 1'b0;
      sweep_done <= 1'b0;
      sweep_sig  <= '0;
    end else begin
      cfg_done   <= 1'b0;
      sweep_done <= 1'b0;
      case (state)
        IDLE: begin
          if (load_enter) begin
            shadow <= '0;
            cnt    <= '0;
          end else if (sweep_enter) begin
            sweep_sig  <= '0;
            sweep_busy <= 1'b1;
            cnt        <= '0;
          end
        end
        LOAD: begin
          if (bit_acc) begin
            shadow <= shadow_nxt;
            cnt    <= cnt + 1'b1;
            if (load_commit) begin
              tt       <= shadow_nxt;
              cfg_done <= 1'b1;
            end
          end
        end
        SWEEP: begin
          sweep_sig[idx] <= tt[idx];
          cnt            <= cnt + 1'b1;
          if (sweep_last) begin
            sweep_busy <= 1'b0;
            sweep_done <= 1'b1;
          end
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_eval.sv
// Bench for truth_table_eval: 4-input default instance plus a 2-input XOR
// instance. Evaluation results of the 4-input instance go through a queue.
`timescale 1ns/1ps
module tb_truth_table_eval;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, cfg_load, cfg_bit_valid, cfg_bit, sweep_start;
  logic [3:0]  in_data;
  logic        in_ready, out_valid, out, cfg_done, sweep_busy, sweep_done;
  logic [15:0] sweep_sig;

  logic        b_in_valid, b_cfg_load, b_cfg_bit_valid, b_cfg_bit, b_sweep_start;
  logic [1:0]  b_in_data;
  logic        b_in_ready, b_out_valid, b_out, b_cfg_done, b_sweep_busy, b_sweep_done;
  logic [3:0]  b_sweep_sig;

  truth_table_eval dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out(out),
    .cfg_load(cfg_load), .cfg_bit_valid(cfg_bit_valid), .cfg_bit(cfg_bit),
    .cfg_done(cfg_done),
    .sweep_start(sweep_start), .sweep_busy(sweep_busy),
    .sweep_done(sweep_done), .sweep_sig(sweep_sig)
  );

  truth_table_eval #(.N_IN(2), .DEFAULT_TT(4'h6)) dut_xor (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out(b_out),
    .cfg_load(b_cfg_load), .cfg_bit_valid(b_cfg_bit_valid), .cfg_bit(b_cfg_bit),
    .cfg_done(b_cfg_done),
    .sweep_start(b_sweep_start), .sweep_busy(b_sweep_busy),
    .sweep_done(b_sweep_done), .sweep_sig(b_sweep_sig)
  );

  int   n_vec = 0;
  int   n_err = 0;
  int   cfg_done_cnt = 0;
  logic exp_q[$];
  logic mon_exp;

  // Scoreboard: every out_valid must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && cfg_done === 1'b1) cfg_done_cnt++;
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_out_valid: out_valid=1 with no evaluation pending (out=%b)", out);
      end else begin
        mon_exp = exp_q.pop_front();
        if (out !== mon_exp) begin
          n_err++;
          $display("FAIL eval_out: got %b expected %b", out, mon_exp);
        end
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    in_valid = 0; in_data = '0; cfg_load = 0; cfg_bit_valid = 0; cfg_bit = 0; sweep_start = 0;
    b_in_valid = 0; b_in_data = '0; b_cfg_load = 0; b_cfg_bit_valid = 0; b_cfg_bit = 0; b_sweep_start = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One back-to-back-capable evaluation; the caller ends a burst with end_eval.
  task automatic drive_eval(input logic [3:0] v, input logic e);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = v;
    exp_q.push_back(e);
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL eval_in_ready: in_ready=%b expected 1 (v=%0d)", in_ready, v);
    end
  endtask

  task automatic end_eval();
    @(posedge clk); #1 in_valid = 1'b0;
  endtask

  task automatic check_drained(input string name);
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_drain: %0d results missing, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    drive_eval(4'd1, 1'b1);
    end_eval();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({out, out_valid, cfg_done, sweep_busy, sweep_done} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_outputs: out,ov,cd,sb,sd=%b expected 00000", {out, out_valid, cfg_done, sweep_busy, sweep_done});
    end
    n_vec++;
    if (sweep_sig !== 16'h0) begin
      n_err++;
      $display("FAIL reset_sweep_sig: got %h expected 0000", sweep_sig);
    end
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    exp_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_default_eval();
    drive_eval(4'd0, 1'b0);
    drive_eval(4'd1, 1'b1);
    drive_eval(4'd12, 1'b1);
    drive_eval(4'd15, 1'b0);
    drive_eval(4'd1, 1'b1);
    end_eval();
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0 || out !== 1'b1) begin
      n_err++;
      $display("FAIL eval_hold: out_valid=%b out=%b expected 0 1", out_valid, out);
    end
    check_drained("default_eval");
  endtask

  task automatic test_sweep(input logic [15:0] exp_sig);
    int          busy_cnt;
    bit          seen_done;
    logic [15:0] mask;
    busy_cnt  = 0;
    seen_done = 0;
    @(posedge clk); #1 sweep_start = 1'b1;
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL sweep_req_in_ready: got %b expected 0", in_ready);
    end
    @(posedge clk); #1 sweep_start = 1'b0;
    for (int k = 0; k < 40 && !seen_done; k++) begin
      @(negedge clk);
      if (sweep_done === 1'b1) begin
        seen_done = 1;
      end else if (sweep_busy === 1'b1) begin
        mask = (16'h1 << busy_cnt) - 16'h1;
        n_vec++;
        if (sweep_sig !== (exp_sig & mask)) begin
          n_err++;
          $display("FAIL sweep_partial: cycle %0d sig=%h expected %h", busy_cnt, sweep_sig, exp_sig & mask);
        end
        n_vec++;
        if (in_ready !== 1'b0) begin
          n_err++;
          $display("FAIL sweep_in_ready: got %b expected 0", in_ready);
        end
        busy_cnt++;
      end
    end
    n_vec++;
    if (!seen_done || sweep_busy !== 1'b0) begin
      n_err++;
      $display("FAIL sweep_done_seen: done=%0d busy=%b expected done=1 busy=0", seen_done, sweep_busy);
    end
    n_vec++;
    if (busy_cnt != 16) begin
      n_err++;
      $display("FAIL sweep_busy_cycles: got %0d expected 16", busy_cnt);
    end
    n_vec++;
    if (sweep_sig !== exp_sig) begin
      n_err++;
      $display("FAIL sweep_sig: got %h expected %h", sweep_sig, exp_sig);
    end
    @(negedge clk);
    n_vec++;
    if (sweep_done !== 1'b0 || in_ready !== 1'b1 || sweep_sig !== exp_sig) begin
      n_err++;
      $display("FAIL sweep_after: done=%b in_ready=%b sig=%h expected 0 1 %h", sweep_done, in_ready, sweep_sig, exp_sig);
    end
  endtask

  task automatic test_load_gaps();
    logic [15:0] pat;
    int          done0;
    pat   = 16'h00FF;
    done0 = cfg_done_cnt;
    @(posedge clk); #1 cfg_bit_valid = 1'b1; cfg_bit = 1'b1;
    @(posedge clk); #1 cfg_bit_valid = 1'b0; cfg_load = 1'b1;
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL load_req_in_ready: got %b expected 0", in_ready);
    end
    @(posedge clk); #1 cfg_load = 1'b0;
    for (int i = 0; i < 16; i++) begin
      for (int g = 0; g < i % 3; g++) begin
        if (i == 5) begin
          in_valid = 1'b1; in_data = 4'd8; sweep_start = 1'b1; cfg_load = 1'b1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; sweep_start = 1'b0; cfg_load = 1'b0;
      end
      cfg_bit_valid = 1'b1;
      cfg_bit       = pat[i];
      @(posedge clk); #1 cfg_bit_valid = 1'b0;
      if (i < 15) begin
        @(negedge clk);
        n_vec++;
        if (cfg_done !== 1'b0 || in_ready !== 1'b0 || sweep_busy !== 1'b0) begin
          n_err++;
          $display("FAIL load_progress: bit %0d cfg_done=%b in_ready=%b busy=%b expected 0 0 0", i, cfg_done, in_ready, sweep_busy);
        end
      end
    end
    @(negedge clk);
    n_vec++;
    if (cfg_done !== 1'b1 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL load_commit: cfg_done=%b in_ready=%b expected 1 1", cfg_done, in_ready);
    end
    @(negedge clk);
    n_vec++;
    if (cfg_done !== 1'b0) begin
      n_err++;
      $display("FAIL load_done_pulse: cfg_done=%b expected 0", cfg_done);
    end
    @(posedge clk); #1;
    n_vec++;
    if (cfg_done_cnt - done0 != 1) begin
      n_err++;
      $display("FAIL load_done_count: got %0d expected 1", cfg_done_cnt - done0);
    end
    drive_eval(4'd8, 1'b0);
    drive_eval(4'd3, 1'b1);
    drive_eval(4'd7, 1'b1);
    drive_eval(4'd9, 1'b0);
    end_eval();
    check_drained("load_eval");
    test_sweep(16'h00FF);
  endtask

  task automatic test_priority_midload_reset();
    int done0;
    done0 = cfg_done_cnt;
    @(posedge clk); #1;
    cfg_load = 1'b1; sweep_start = 1'b1; in_valid = 1'b1; in_data = 4'd8;
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL prio_in_ready: got %b expected 0", in_ready);
    end
    @(posedge clk); #1;
    cfg_load = 1'b0; sweep_start = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (sweep_busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL prio_state: busy=%b out_valid=%b in_ready=%b expected 0 0 0", sweep_busy, out_valid, in_ready);
    end
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1 cfg_bit_valid = 1'b1; cfg_bit = 1'b1;
    end
    @(posedge clk); #1 cfg_bit_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b0 || cfg_done !== 1'b0) begin
      n_err++;
      $display("FAIL midload_state: in_ready=%b cfg_done=%b expected 0 0", in_ready, cfg_done);
    end
    apply_reset();
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (cfg_done_cnt != done0) begin
      n_err++;
      $display("FAIL midload_no_done: got %0d pulses expected 0", cfg_done_cnt - done0);
    end
    drive_eval(4'd1, 1'b1);
    drive_eval(4'd8, 1'b1);
    drive_eval(4'd0, 1'b0);
    end_eval();
    check_drained("midload_reset");
  endtask

  task automatic test_n2_xor();
    int busy_cnt;
    bit seen_done;
    busy_cnt  = 0;
    seen_done = 0;
    @(posedge clk); #1 b_sweep_start = 1'b1;
    @(posedge clk); #1 b_sweep_start = 1'b0;
    for (int k = 0; k < 20 && !seen_done; k++) begin
      @(negedge clk);
      if (b_sweep_done === 1'b1) begin
        seen_done = 1;
      end else if (b_sweep_busy === 1'b1) begin
        n_vec++;
        if (b_in_ready !== 1'b0) begin
          n_err++;
          $display("FAIL xor_sweep_in_ready: got %b expected 0", b_in_ready);
        end
        busy_cnt++;
      end
    end
    n_vec++;
    if (!seen_done || busy_cnt != 4) begin
      n_err++;
      $display("FAIL xor_sweep_cycles: done=%0d busy=%0d expected done=1 busy=4", seen_done, busy_cnt);
    end
    n_vec++;
    if (b_sweep_sig !== 4'h6) begin
      n_err++;
      $display("FAIL xor_sweep_sig: got %h expected 6", b_sweep_sig);
    end
    for (int v = 0; v < 4; v++) begin
      @(posedge clk); #1 b_in_valid = 1'b1; b_in_data = 2'(v);
      @(posedge clk); #1 b_in_valid = 1'b0;
      @(negedge clk);
      n_vec++;
      if (b_out_valid !== 1'b1 || b_out !== ((v == 1 || v == 2) ? 1'b1 : 1'b0)) begin
        n_err++;
        $display("FAIL xor_eval: v=%0d out_valid=%b out=%b expected 1 %b", v, b_out_valid, b_out, (v == 1 || v == 2));
      end
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_default_eval();
    test_sweep(16'h1FDE);
    test_load_gaps();
    test_priority_midload_reset();
    test_n2_xor();
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/truth_table_eval.md
TRUTH_TABLE_EVAL -- requirements
Module: truth_table_eval

Interface
REQ-001 SHALL have parameter N_IN, default 4, meaning number of logic inputs; legal range 2..6.
REQ-002 SHALL have parameter DEFAULT_TT, default 16'h1FDE (2**N_IN bits), meaning the truth table loaded at reset.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: in_data carries a vector to evaluate.
REQ-006 SHALL have port in_data, input, N_IN bits: input vector v, unsigned, used as the truth-table address.
REQ-007 SHALL have port in_ready, output, 1 bit: block accepts an evaluation this cycle.
REQ-008 SHALL have port out_valid, output, 1 bit: out is valid; one-cycle pulse.
REQ-009 SHALL have port out, output, 1 bit: the evaluated function value.
REQ-010 SHALL have port cfg_load, input, 1 bit: request to start a serial truth-table load.
REQ-011 SHALL have port cfg_bit_valid, input, 1 bit: cfg_bit is valid this cycle.
REQ-012 SHALL have port cfg_bit, input, 1 bit: next truth-table bit, LSB first.
REQ-013 SHALL have port cfg_done, output, 1 bit: one-cycle pulse when a new table is committed.
REQ-014 SHALL have port sweep_start, input, 1 bit: request an exhaustive self-sweep.
REQ-015 SHALL have port sweep_busy, output, 1 bit: sweep in progress.
REQ-016 SHALL have port sweep_done, output, 1 bit: one-cycle pulse when sweep_sig is complete.
REQ-017 SHALL have port sweep_sig, output, 2**N_IN bits: the captured sweep results, bit v = f(v).

Function
REQ-018 SHALL implement the FSM states IDLE, LOAD and SWEEP.
REQ-019 SHALL hold an active table TT (2**N_IN bits); f(v) = TT[v].
REQ-020 SHALL, in IDLE, give priority cfg_load > sweep_start > in_valid.
REQ-021 SHALL drive in_ready = (state==IDLE) & ~cfg_load & ~sweep_start, combinationally.
REQ-022 SHALL, on a cycle with in_valid & in_ready, register out <= TT[in_data] and out_valid <= 1, so latency is 1 cycle.
REQ-023 SHALL, when no evaluation is accepted, deassert out_valid next cycle while out holds its last value.
REQ-024 SHALL, when cfg_load is seen in IDLE, enter LOAD with bit counter = 0 and clear the shadow table.
REQ-025 SHALL, in LOAD on each cfg_bit_valid, write shadow[counter] <= cfg_bit and increment the counter; cycles without cfg_bit_valid stall with no timeout.
REQ-026 SHALL, on accepting bit 2**N_IN-1, copy shadow to TT, pulse cfg_done next cycle and return to IDLE.
REQ-027 SHALL leave TT unchanged during LOAD, with cfg_load/sweep_start/in_valid ignored outside IDLE.
REQ-028 SHALL, when sweep_start is accepted in IDLE, enter SWEEP with v = 0, hold sweep_busy high for exactly 2**N_IN cycles and write sweep_sig[v] <= TT[v] each cycle with v incrementing.
REQ-029 SHALL, after the last vector, return to IDLE and pulse sweep_done in the first IDLE cycle, with sweep_sig equal to TT.
REQ-030 SHALL clear sweep_sig to 0 at sweep entry; sweep_sig otherwise holds its value until the next sweep.
REQ-031 SHALL make the counter/vector N_IN+1 bits wide so there is no wrap at 2**N_IN; termination is by compare with 2**N_IN-1.
REQ-032 SHALL ignore cfg_bit_valid outside LOAD.

Reset
REQ-033 SHALL, while rst_n is low, immediately set state=IDLE, TT=DEFAULT_TT, shadow=0, counter=0, out=0, out_valid=0, cfg_done=0, sweep_busy=0, sweep_done=0 and sweep_sig=0.
REQ-034 SHALL, on reset during LOAD or SWEEP, abandon the operation with no cfg_done/sweep_done and restore TT to DEFAULT_TT.
REQ-035 SHALL resume normal operation on the first rising clk edge after rst_n deasserts.

Verification
REQ-036 SHALL cover default evaluation: after reset, evaluate in_data = 0,1,12,15 -> out = 0,1,1,0 each one cycle later with out_valid pulses.
REQ-037 SHALL cover the sweep: sweep_start in IDLE -> sweep_busy high 16 cycles, then sweep_done pulse with sweep_sig=16'h1FDE; in_ready low throughout.
REQ-038 SHALL cover a load with gaps: cfg_load, then 16 bits of 16'h00FF with idle gaps -> cfg_done once; evaluate 8 -> 0, evaluate 3 -> 1; TT stays 16'h1FDE until commit.
REQ-039 SHALL cover priority: cfg_load, sweep_start and in_valid in the same IDLE cycle -> LOAD entered, in_ready=0, no out_valid, no sweep_busy.
REQ-040 SHALL cover reset mid-load: rst_n low after 7 bits of a load -> no cfg_done, evaluate 1 -> 1 (default table).
REQ-041 SHALL cover N_IN=2 with DEFAULT_TT=4'h6 (XOR): sweep -> sweep_sig=4'h6 after 4 busy cycles.
